// File: rtl/puf_uart_host.sv
// Host-side initiator for the PUF UART challenge/response link: sends one challenge
// byte, gathers N_BYTES response bytes (first byte ends up in the MSB), with an idle-timeout abort.
module puf_uart_host #(
    parameter int N_BYTES        = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0]             challenge,
    output logic [7:0]             tx_byte,
    output logic                   tx_DV,
    input  logic                   tx_done,
    input  logic                   rx_DV,
    input  logic [7:0]             rx_byte,
    output logic [8*N_BYTES-1:0]   response,
    output logic                   done,
    output logic                   timeout,
    output logic                   busy,
    output logic [5:0]             byte_count
);
    localparam int              RW     = 8 * N_BYTES;
    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]      N_LAST = 6'(N_BYTES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, FINISH} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   shift_q, shift_d;
    logic [RW-1:0]   resp_q, resp_d;
    logic [7:0]      txb_q, txb_d;
    logic            txdv_q, txdv_d;
    logic            done_q, done_d;
    logic            to_q, to_d;
    logic            busy_q, busy_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            resp_q  <= '0;
            txb_q   <= '0;
            txdv_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            resp_q  <= resp_d;
            txb_q   <= txb_d;
            txdv_q  <= txdv_d;
            done_q  <= done_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

    // done/busy/response are updated on the final-byte edge so that done is
    // visible during FINISH together with the new response.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        resp_d  = resp_q;
        txb_d   = txb_q;
        txdv_d  = 1'b0;
        done_d  = 1'b0;
        to_d    = to_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    txb_d   = challenge;
                    txdv_d  = 1'b1;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: begin
                if (tx_done) begin
                    tmr_d   = '0;
                    state_d = RECV;
                end else if (tmr_q == T_LAST) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            RECV: begin
                if (rx_DV) begin
                    shift_d = {shift_q[RW-9:0], rx_byte};
                    cnt_d   = cnt_q + 6'd1;
                    tmr_d   = '0;
                    if (cnt_q == N_LAST) begin
                        resp_d  = shift_d;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end
                end else if (tmr_q == T_LAST) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign tx_byte    = txb_q;
    assign tx_DV      = txdv_q;
    assign response   = resp_q;
    assign done       = done_q;
    assign timeout    = to_q;
    assign busy       = busy_q;
    assign byte_count = cnt_q;
endmodule

// File: tb/tb_puf_uart_host.sv
// Randomized scoreboard bench for puf_uart_host: stimulus pushes expected tx/done/timeout
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_puf_uart_host;
    localparam int NB = 32;
    localparam int TO = 64;

    logic         clk = 1'b0, reset_n = 1'b1, start = 1'b0, tx_done = 1'b0, rx_DV = 1'b0;
    logic [7:0]   challenge = 8'h00, rx_byte = 8'h00;
    logic [7:0]   tx_byte;
    logic         tx_DV, done, timeout, busy;
    logic [5:0]   byte_count;
    logic [8*NB-1:0] response;

    puf_uart_host #(.N_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .challenge(challenge),
        .tx_byte(tx_byte), .tx_DV(tx_DV), .tx_done(tx_done), .rx_DV(rx_DV),
        .rx_byte(rx_byte), .response(response), .done(done), .timeout(timeout),
        .busy(busy), .byte_count(byte_count)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct { bit is_to; logic [255:0] resp; int cnt; int cyc; } ev_t;
    typedef struct { logic [7:0] b; int cyc; } tx_t;
    ev_t evq[$];
    tx_t txq[$];
    logic [255:0] model_resp = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One input cycle: values set just after an edge are sampled at the next edge.
    task automatic step(input bit s, input logic [7:0] c, input bit td, input bit rv, input logic [7:0] rb);
        @(posedge clk);
        #1;
        start = s; challenge = c; tx_done = td; rx_DV = rv; rx_byte = rb;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    // Reference: the response is simply the received bytes concatenated in order,
    // done appears the cycle after the last byte, timeout TO cycles after the last event.
    task automatic txn(input logic [7:0] ch, input int nb, input bit inc, input int wg,
                       input int edge_i, input bit spur, input bit expect_to);
        logic [255:0] acc;
        logic [7:0]   b;
        acc = '0;
        step(1'b1, ch, 1'b0, 1'b0, 8'h00);
        txq.push_back('{ch, cyc + 1});
        step(spur, 8'h5A, 1'b0, spur, 8'hFF);
        for (int g = 0; g < wg; g++)
            step(spur && ($urandom_range(0, 1) == 1), 8'($urandom), 1'b0,
                 spur && ($urandom_range(0, 1) == 1), 8'hFF);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < nb; i++) begin
            int gap;
            gap = (i == edge_i) ? TO - 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++)
                step(spur && ($urandom_range(0, 1) == 1), 8'($urandom), 1'b0, 1'b0, 8'h00);
            b = inc ? 8'(i) : 8'($urandom);
            step(1'b0, 8'h00, 1'b0, 1'b1, b);
            acc = {acc[247:0], b};
        end
        if (nb == NB) begin
            model_resp = acc;
            evq.push_back('{1'b0, acc, NB, cyc + 1});
        end else if (expect_to) begin
            evq.push_back('{1'b1, model_resp, nb, cyc + 1 + TO});
            idle(TO + 4);
        end
    endtask

    initial begin : mon
        logic to_prev;
        ev_t  e;
        tx_t  t;
        to_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                to_prev = 1'b0;
                continue;
            end
            if (tx_DV) begin
                if (txq.size() == 0) chki("tx_dv_unexpected", int'(tx_DV), 0);
                else begin
                    t = txq.pop_front();
                    chki("tx_byte", int'(tx_byte), int'(t.b));
                    chki("tx_cycle", cyc, t.cyc);
                    chki("busy_at_tx", int'(busy), 1);
                end
            end
            if (done) begin
                if (evq.size() == 0) chki("done_unexpected", int'(done), 0);
                else begin
                    e = evq.pop_front();
                    if (e.is_to) chki("done_instead_of_timeout", int'(done), 0);
                    else begin
                        chk("response", response, e.resp);
                        chki("done_cycle", cyc, e.cyc);
                        chki("busy_at_done", int'(busy), 0);
                        chki("timeout_at_done", int'(timeout), 0);
                    end
                end
            end
            if (timeout && !to_prev) begin
                if (evq.size() == 0) chki("timeout_unexpected", int'(timeout), 0);
                else begin
                    e = evq.pop_front();
                    if (!e.is_to) chki("timeout_instead_of_done", int'(timeout), 0);
                    else begin
                        chk("response_after_timeout", response, e.resp);
                        chki("timeout_byte_count", int'(byte_count), e.cnt);
                        chki("timeout_cycle", cyc, e.cyc);
                        chki("busy_at_timeout", int'(busy), 0);
                    end
                end
            end
            to_prev = timeout;
        end
    end

    task automatic check_all_zero(input string tag);
        chki({tag, "_busy"}, int'(busy), 0);
        chki({tag, "_done"}, int'(done), 0);
        chki({tag, "_timeout"}, int'(timeout), 0);
        chki({tag, "_tx_dv"}, int'(tx_DV), 0);
        chki({tag, "_tx_byte"}, int'(tx_byte), 0);
        chki({tag, "_byte_count"}, int'(byte_count), 0);
        chk({tag, "_response"}, response, '0);
    endtask

    initial begin
        #10 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        idle(2);

        // nominal: A5, bytes 00..1F
        txn(8'hA5, NB, 1'b1, 2, -1, 1'b0, 1'b0);
        idle(3);

        // silence after 5 bytes, then stray bytes in IDLE
        txn(8'($urandom), 5, 1'b0, 1, -1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
        idle(2);

        // events landing exactly on the last timer cycle
        txn(8'($urandom), NB, 1'b0, TO - 1, 10, 1'b0, 1'b0);
        idle(2);

        // spurious starts and stray bytes while busy
        txn(8'($urandom), NB, 1'b0, 4, -1, 1'b1, 1'b0);
        idle(2);
        for (int r = 0; r < 3; r++) begin
            txn(8'($urandom), NB, 1'b0, int'($urandom_range(0, 6)), -1, 1'($urandom), 1'b0);
            idle(int'($urandom_range(1, 3)));
        end

        // reset after 10 bytes
        txn(8'($urandom), 10, 1'b0, 1, -1, 1'b0, 1'b0);
        idle(1);
        #10 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        chki("midreset_evq_empty", evq.size(), 0);
        model_resp = '0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        txn(8'h3C, NB, 1'b0, 3, -1, 1'b0, 1'b0);

        // start during FINISH is ignored, the next one is accepted
        step(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        txn(8'h01, NB, 1'b0, 2, -1, 1'b0, 1'b0);
        idle(10);

        chki("evq_drained", evq.size(), 0);
        chki("txq_drained", txq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
